rotqmby_pipe: RTL and testbench



---
 rtl/rotqmby_pipe.sv | 93 +++++++++
 tb/tb_rotqmby_pipe.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotqmby_pipe.sv
// rotqmby_pipe: three-stage logical right byte shift of a quadword
// (rotqmby / rotqmbyi) with a valid/ready handshake and whole-pipe stall.
module rotqmby_pipe #(
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             imm_sel,
    input  logic [0:127]     ra,
    input  logic [0:127]     rb,
    input  logic [0:6]       i7,
    input  logic [0:TAG_W-1] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     result,
    output logic [0:TAG_W-1] tag_out
);

    logic [0:4]       raw;
    logic [0:4]       s;
    logic             stall;
    logic             accept;
    logic             unused_bits;

    logic             v1, v2, v3;
    logic [0:127]     d1, d2, d3;
    logic [0:4]       s1;
    logic [0:2]       s2;
    logic [0:TAG_W-1] t1, t2, t3;

    logic [0:127]     sh1, sh2, sh4, sh8;

    // The instruction counts are negated: a "right by n" request is -n.
    assign raw = imm_sel ? i7[2:6] : rb[27:31];
    assign s   = 5'd0 - raw;

    assign unused_bits = ^{rb[0:26], rb[32:127], i7[0:1]};

    assign stall    = v3 & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // S2 logic: 1- and 2-byte steps
    assign sh1 = s1[4] ? (d1 >> 8)  : d1;
    assign sh2 = s1[3] ? (sh1 >> 16) : sh1;

    // S3 logic: 4- and 8-byte steps; s2[0] means s >= 16
    assign sh4 = s2[2] ? (d2 >> 32)  : d2;
    assign sh8 = s2[1] ? (sh4 >> 64) : sh4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            s1 <= '0;
            s2 <= '0;
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
        end else begin
            if (!stall) begin
                v1 <= accept;
                v2 <= v1;
                v3 <= v2;
                d1 <= ra;
                s1 <= s;
                t1 <= tag_in;
                d2 <= sh2;
                s2 <= s1[0:2];
                t2 <= t1;
                d3 <= s2[0] ? '0 : sh8;
                t3 <= t2;
            end
            if (flush) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
                v3 <= 1'b0;
            end
        end
    end

    assign out_valid = v3;
    assign result    = d3;
    assign tag_out   = t3;

endmodule

// File: tb/tb_rotqmby_pipe.sv
// tb_rotqmby_pipe: randomized bench for rotqmby_pipe, checked against a
// byte-level reference model and a FIFO scoreboard.
module tb_rotqmby_pipe;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           imm_sel;
    logic [0:127]   ra;
    logic [0:127]   rb;
    logic [0:6]     i7;
    logic [0:6]     tag_in;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   result;
    logic [0:6]     tag_out;

    int checks = 0;
    int errors = 0;

    localparam logic [0:127] RA0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [0:127] RA1 = 128'hA5112233445566778899AABBCCDDEEFF;

    rotqmby_pipe #(.TAG_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .ra        (ra),
        .rb        (rb),
        .i7        (i7),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: result byte k = ra byte (k - s) when 0 <= k - s, s < 16.
    function automatic logic [0:127] model(input logic [0:127] a,
                                           input logic imm,
                                           input logic [0:127] b,
                                           input logic [0:6] i);
        int raw;
        int s;
        logic [0:127] r;
        raw = imm ? int'(i[2:6]) : int'(b[27:31]);
        s = (32 - raw) % 32;
        r = '0;
        for (int k = 0; k < 16; k++)
            if (s <= 15 && k >= s)
                r[8*k +: 8] = a[8*(k-s) +: 8];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat on an idle pipe, wait for it, then retire it.
    task automatic run_single(input logic [0:127] a, input logic imm,
                              input logic [0:127] b, input logic [0:6] i,
                              input logic [0:6] t,
                              output logic [0:127] r,
                              output logic [0:6] to, output int lat);
        ra = a;
        imm_sel = imm;
        rb = b;
        i7 = i;
        tag_in = t;
        in_valid = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        do begin
            cyc();
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        r = result;
        to = tag_out;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        imm_sel = 1'b0;
        ra = '0;
        rb = '0;
        i7 = '0;
        tag_in = '0;
        repeat (2) cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (result !== 128'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        checks++;
        if (tag_out !== 7'h0) begin
            errors++;
            $display("FAIL reset_tag: got %h want 0", tag_out);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [0:127] b;
        logic [0:127] r;
        logic [0:6] to;
        int lat;
        b = rnd128();
        b[27:31] = 5'd31;
        run_single(RA0, 1'b0, b, 7'($urandom), 7'h2A, r, to, lat);
        checks++;
        if (r !== 128'h0000112233445566778899AABBCCDDEE) begin
            errors++;
            $display("FAIL basic_result: got %h want %h", r,
                     128'h0000112233445566778899AABBCCDDEE);
        end
        checks++;
        if (to !== 7'h2A) begin
            errors++;
            $display("FAIL basic_tag: got %h want 2a", to);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_counts();
        int raws[4] = '{0, 17, 16, 1};
        logic [0:127] exps[4];
        logic [0:127] b;
        logic [0:127] a;
        logic [0:6] i;
        logic imm;
        logic [0:127] r;
        logic [0:6] to;
        int lat;
        exps[0] = RA1;
        exps[1] = 128'h000000000000000000000000000000A5;
        exps[2] = 128'h0;
        exps[3] = 128'h0;
        for (int k = 0; k < 4; k++) begin
            b = rnd128();
            b[27:31] = 5'(raws[k]);
            run_single(RA1, 1'b0, b, 7'($urandom), 7'(k), r, to, lat);
            checks++;
            if (r !== exps[k]) begin
                errors++;
                $display("FAIL count_raw%0d: got %h want %h",
                         raws[k], r, exps[k]);
            end
        end
        for (int c = 0; c < 32; c++) begin
            a = rnd128();
            b = rnd128();
            i = 7'($urandom);
            imm = 1'($urandom);
            if (imm) i[2:6] = 5'(c);
            else b[27:31] = 5'(c);
            run_single(a, imm, b, i, 7'(c), r, to, lat);
            checks++;
            if (r !== model(a, imm, b, i) || to !== 7'(c)) begin
                errors++;
                $display("FAIL count_sweep%0d: got %h/%h want %h/%h", c,
                         r, to, model(a, imm, b, i), 7'(c));
            end
        end
    endtask

    task automatic test_imm();
        logic [0:127] r;
        logic [0:6] to;
        int lat;
        logic [0:127] want;
        want = 128'h0000000000112233445566778899AABB;
        run_single(RA0, 1'b1, rnd128(), 7'h7C, 7'h11, r, to, lat);
        checks++;
        if (r !== want) begin
            errors++;
            $display("FAIL imm_7c: got %h want %h", r, want);
        end
        run_single(RA0, 1'b1, rnd128(), 7'h1C, 7'h12, r, to, lat);
        checks++;
        if (r !== want || to !== 7'h12) begin
            errors++;
            $display("FAIL imm_dontcare: got %h/%h want %h/12", r, to, want);
        end
    endtask

    task automatic test_stream_stall();
        logic [0:127] eq[$];
        logic [0:6] tq[$];
        logic [0:127] held;
        logic [0:6] heldt;
        logic [0:127] er;
        logic [0:6] et;
        int sent = 0;
        int got = 0;
        int stall_cnt = 0;
        int cycles = 0;
        held = '0;
        heldt = '0;
        while (got < 6 && cycles < 60) begin
            out_ready = !(out_valid && tag_out == 7'h12 && stall_cnt < 4);
            in_valid = (sent < 6);
            ra = rnd128();
            rb = rnd128();
            i7 = 7'($urandom);
            imm_sel = 1'($urandom);
            tag_in = 7'(8'h10 + sent);
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
                if (stall_cnt == 0) begin
                    held = result;
                    heldt = tag_out;
                end else begin
                    checks++;
                    if (result !== held || tag_out !== heldt
                        || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold: got %h/%h want %h/%h",
                                 result, tag_out, held, heldt);
                    end
                end
                stall_cnt++;
            end
            if (in_valid && in_ready) begin
                eq.push_back(model(ra, imm_sel, rb, i7));
                tq.push_back(tag_in);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious: got tag %h want none",
                             tag_out);
                end else begin
                    er = eq.pop_front();
                    et = tq.pop_front();
                    if (result !== er || tag_out !== et) begin
                        errors++;
                        $display("FAIL stream_beat%0d: got %h/%h want %h/%h",
                                 got, result, tag_out, er, et);
                    end
                end
                got++;
            end
            cyc();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 6 || sent !== 6 || stall_cnt !== 4) begin
            errors++;
            $display("FAIL stream_count: got %0d/%0d/%0d want 6/6/4",
                     got, sent, stall_cnt);
        end
        cyc();
    endtask

    task automatic test_flush();
        logic [0:127] a;
        logic [0:127] b;
        logic [0:127] r;
        logic [0:6] to;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ra = rnd128();
            rb = rnd128();
            imm_sel = 1'b0;
            tag_in = 7'(8'h20 + k);
            in_valid = 1'b1;
            cyc();
        end
        checks++;
        if (out_valid !== 1'b1 || tag_out !== 7'h20) begin
            errors++;
            $display("FAIL flush_pre: got %b/%h want 1/20", out_valid, tag_out);
        end
        out_ready = 1'b0;
        flush = 1'b1;
        tag_in = 7'h23;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        repeat (4) begin
            cyc();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_leak: got %0d beats want 0", seen);
        end
        a = rnd128();
        b = rnd128();
        run_single(a, 1'b0, b, 7'h0, 7'h24, r, to, lat);
        checks++;
        if (r !== model(a, 1'b0, b, 7'h0) || to !== 7'h24 || lat !== 3) begin
            errors++;
            $display("FAIL flush_after: got %h/%h/%0d want %h/24/3",
                     r, to, lat, model(a, 1'b0, b, 7'h0));
        end
    endtask

    task automatic test_reset_mid();
        logic [0:127] a;
        logic [0:127] b;
        logic [0:127] r;
        logic [0:6] to;
        int lat;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ra = RA1;
            rb = '0;
            imm_sel = 1'b0;
            tag_in = 7'(8'h30 + k);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b1 || result !== RA1) begin
            errors++;
            $display("FAIL rstmid_pre: got %b/%h want 1/%h",
                     out_valid, result, RA1);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 128'h0 || tag_out !== 7'h0) begin
            errors++;
            $display("FAIL rstmid_async: got %b/%h/%h want 0/0/0",
                     out_valid, result, tag_out);
        end
        #2;
        reset = 1'b1;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: got %b/%b want 1/0",
                     in_ready, out_valid);
        end
        a = rnd128();
        b = rnd128();
        run_single(a, 1'b0, b, 7'h0, 7'h35, r, to, lat);
        checks++;
        if (r !== model(a, 1'b0, b, 7'h0) || to !== 7'h35 || lat !== 3) begin
            errors++;
            $display("FAIL rstmid_after: got %h/%h/%0d want %h/35/3",
                     r, to, lat, model(a, 1'b0, b, 7'h0));
        end
    endtask

    task automatic test_random();
        logic [0:127] eq[$];
        logic [0:6] tq[$];
        logic [0:127] er;
        logic [0:6] et;
        logic pst;
        logic [0:127] pr;
        logic [0:6] pt;
        int n;
        pst = 1'b0;
        pr = '0;
        pt = '0;
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ra = rnd128();
            rb = rnd128();
            i7 = 7'($urandom);
            imm_sel = 1'($urandom);
            tag_in = 7'($urandom);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready: got %b want %b", in_ready,
                         !(out_valid && !out_ready));
            end
            if (pst) begin
                checks++;
                if (out_valid !== 1'b1 || result !== pr || tag_out !== pt) begin
                    errors++;
                    $display("FAIL rand_hold: got %b/%h/%h want 1/%h/%h",
                             out_valid, result, tag_out, pr, pt);
                end
            end
            if (in_valid && in_ready) begin
                eq.push_back(model(ra, imm_sel, rb, i7));
                tq.push_back(tag_in);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got tag %h want none",
                             tag_out);
                end else begin
                    er = eq.pop_front();
                    et = tq.pop_front();
                    if (result !== er || tag_out !== et) begin
                        errors++;
                        $display("FAIL rand_beat: got %h/%h want %h/%h",
                                 result, tag_out, er, et);
                    end
                end
            end
            pst = out_valid && !out_ready;
            pr = result;
            pt = tag_out;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (eq.size() > 0 && n < 20) begin
            #1;
            if (out_valid) begin
                er = eq.pop_front();
                et = tq.pop_front();
                checks++;
                if (result !== er || tag_out !== et) begin
                    errors++;
                    $display("FAIL rand_drain: got %h/%h want %h/%h",
                             result, tag_out, er, et);
                end
            end
            cyc();
            n++;
        end
        checks++;
        if (eq.size() !== 0) begin
            errors++;
            $display("FAIL rand_lost: got %0d pending want 0", eq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_counts();
        test_imm();
        test_stream_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
